// File: rtl/lsu_wb_pkg.sv
// Shared types and constants for the LSU GPR writeback block.
package lsu_wb_pkg;

    localparam int unsigned LANES       = 64;
    localparam int unsigned DW          = 32;
    localparam int unsigned SGPR_ADDR_W = 9;
    localparam int unsigned VGPR_ADDR_W = 10;
    localparam int unsigned WFID_W      = 6;
    localparam int unsigned DEPTH_W     = 2;
    localparam int unsigned SGPR_DW_N   = 4;
    localparam int unsigned SGPR_DATA_W = 128;

    // Writeback FSM state enumeration.
    typedef logic [1:0] wb_state_t;
    localparam wb_state_t ST_IDLE = 2'd0;
    localparam wb_state_t ST_WAIT = 2'd1;
    localparam wb_state_t ST_DONE = 2'd2;

    // Issue payload captured on accept (exec mask is held separately, it scales with LANES).
    typedef struct packed {
        logic [WFID_W-1:0]      wfid;
        logic                   gpr;
        logic                   rd;
        logic                   wr;
        logic [DEPTH_W-1:0]     depth;
        logic [SGPR_DW_N-1:0]   sgpr_mask;
        logic [VGPR_ADDR_W-1:0] dest_addr;
    } issue_op_t;

    // Both rd and wr set is treated as a load.
    function automatic logic op_is_load(input issue_op_t op);
        return op.rd;
    endfunction

endpackage

// File: rtl/lsu_wb_addr_gen.sv
// Beat counter and per-beat SGPR/VGPR destination address arithmetic.
module lsu_wb_addr_gen
    import lsu_wb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    input  logic [VGPR_ADDR_W-1:0] base,
    input  logic [DEPTH_W-1:0]     depth,
    output logic [DEPTH_W-1:0]     beat_cnt,
    output logic [SGPR_ADDR_W-1:0] sgpr_addr_c,
    output logic [VGPR_ADDR_W-1:0] vgpr_addr_c,
    output logic                   last_beat_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
        end else if (inc) begin
            beat_cnt <= beat_cnt + DEPTH_W'(1);
        end
    end

    // SGPR beats step by four dwords, VGPR beats by one register; both wrap at the file size.
    always_comb begin
        sgpr_addr_c = base[SGPR_ADDR_W-1:0] + SGPR_ADDR_W'({beat_cnt, 2'b00});
        vgpr_addr_c = base + VGPR_ADDR_W'(beat_cnt);
        last_beat_c = (beat_cnt == depth);
    end

endmodule

// File: rtl/lsu_gpr_writeback.sv
// Tracks one decoded LSU op, writes returned load beats into SGPR/VGPR and retires the op.
module lsu_gpr_writeback #(
    parameter int unsigned LANES = lsu_wb_pkg::LANES,
    parameter int unsigned DW    = lsu_wb_pkg::DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [5:0]            issue_wfid,
    input  logic                  issue_mem_gpr,
    input  logic                  issue_mem_rd,
    input  logic                  issue_mem_wr,
    input  logic [1:0]            issue_gpr_op_depth,
    input  logic [3:0]            issue_sgpr_wr_mask,
    input  logic [9:0]            issue_dest_addr,
    input  logic [LANES-1:0]      issue_exec_mask,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [LANES*DW-1:0]   mem_rsp_data,
    output logic [3:0]            sgpr_wr_en,
    output logic [8:0]            sgpr_wr_addr,
    output logic [127:0]          sgpr_wr_data,
    output logic                  vgpr_wr_en,
    output logic [9:0]            vgpr_wr_addr,
    output logic [LANES-1:0]      vgpr_wr_mask,
    output logic [LANES*DW-1:0]   vgpr_wr_data,
    output logic                  retire_valid,
    output logic [5:0]            retire_wfid
);

    import lsu_wb_pkg::*;

    wb_state_t              state_q;
    wb_state_t              state_d;
    issue_op_t              op_q;
    issue_op_t              issue_op_c;
    logic [LANES-1:0]       exec_q;
    logic [WFID_W-1:0]      wfid_d;
    logic                   issue_acc_c;
    logic                   beat_acc_c;
    logic                   load_beat_c;
    logic [DEPTH_W-1:0]     beat_cnt;
    logic [SGPR_ADDR_W-1:0] sgpr_addr_c;
    logic [VGPR_ADDR_W-1:0] vgpr_addr_c;
    logic                   last_beat_c;

    lsu_wb_addr_gen u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clr         (issue_acc_c),
        .inc         (load_beat_c),
        .base        (op_q.dest_addr),
        .depth       (op_q.depth),
        .beat_cnt    (beat_cnt),
        .sgpr_addr_c (sgpr_addr_c),
        .vgpr_addr_c (vgpr_addr_c),
        .last_beat_c (last_beat_c)
    );

    // Issue payload as presented this cycle.
    always_comb begin
        issue_op_c           = '0;
        issue_op_c.wfid      = issue_wfid;
        issue_op_c.gpr       = issue_mem_gpr;
        issue_op_c.rd        = issue_mem_rd;
        issue_op_c.wr        = issue_mem_wr;
        issue_op_c.depth     = issue_gpr_op_depth;
        issue_op_c.sgpr_mask = issue_sgpr_wr_mask;
        issue_op_c.dest_addr = issue_dest_addr;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d     = state_q;
        wfid_d      = op_q.wfid;
        issue_acc_c = issue_valid && issue_ready;
        beat_acc_c  = mem_rsp_valid && mem_rsp_ready;
        load_beat_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_acc_c) begin
                    wfid_d  = issue_wfid;
                    state_d = (issue_mem_rd || issue_mem_wr) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (beat_acc_c) begin
                    if (!op_is_load(op_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        load_beat_c = 1'b1;
                        if (last_beat_c) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, handshakes, retire and latched op fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            issue_ready   <= 1'b1;
            mem_rsp_ready <= 1'b0;
            retire_valid  <= 1'b0;
            retire_wfid   <= '0;
            op_q          <= '0;
            exec_q        <= '0;
        end else begin
            state_q       <= state_d;
            issue_ready   <= (state_d == ST_IDLE);
            mem_rsp_ready <= (state_d == ST_WAIT);
            retire_valid  <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                retire_wfid <= wfid_d;
            end
            if (issue_acc_c) begin
                op_q   <= issue_op_c;
                exec_q <= issue_exec_mask;
            end
        end
    end

    // GPR write port: one-cycle strobes, address/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgpr_wr_en   <= '0;
            sgpr_wr_addr <= '0;
            sgpr_wr_data <= '0;
            vgpr_wr_en   <= 1'b0;
            vgpr_wr_addr <= '0;
            vgpr_wr_mask <= '0;
            vgpr_wr_data <= '0;
        end else begin
            sgpr_wr_en <= '0;
            vgpr_wr_en <= 1'b0;
            if (load_beat_c && !op_q.gpr) begin
                sgpr_wr_en   <= op_q.sgpr_mask;
                sgpr_wr_addr <= sgpr_addr_c;
                sgpr_wr_data <= mem_rsp_data[SGPR_DATA_W-1:0];
            end
            if (load_beat_c && op_q.gpr) begin
                vgpr_wr_en   <= 1'b1;
                vgpr_wr_addr <= vgpr_addr_c;
                vgpr_wr_mask <= exec_q;
                vgpr_wr_data <= mem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_gpr_writeback.sv
// Randomized self-checking bench for lsu_gpr_writeback against an op-level reference model.
module tb_lsu_gpr_writeback;

    localparam int unsigned LANES = 64;
    localparam int unsigned DW    = 32;
    localparam int unsigned VW    = LANES * DW;
    localparam int unsigned NW    = VW / 32;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [5:0]       issue_wfid;
    logic             issue_mem_gpr;
    logic             issue_mem_rd;
    logic             issue_mem_wr;
    logic [1:0]       issue_gpr_op_depth;
    logic [3:0]       issue_sgpr_wr_mask;
    logic [9:0]       issue_dest_addr;
    logic [LANES-1:0] issue_exec_mask;
    logic             mem_rsp_valid;
    logic             mem_rsp_ready;
    logic [VW-1:0]    mem_rsp_data;
    logic [3:0]       sgpr_wr_en;
    logic [8:0]       sgpr_wr_addr;
    logic [127:0]     sgpr_wr_data;
    logic             vgpr_wr_en;
    logic [9:0]       vgpr_wr_addr;
    logic [LANES-1:0] vgpr_wr_mask;
    logic [VW-1:0]    vgpr_wr_data;
    logic             retire_valid;
    logic [5:0]       retire_wfid;

    int n_chk = 0;
    int n_bad = 0;

    // Last written addresses, expected to hold while strobes are low.
    logic [8:0] last_saddr;
    logic [9:0] last_vaddr;

    lsu_gpr_writeback #(.LANES(LANES), .DW(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_wfid         (issue_wfid),
        .issue_mem_gpr      (issue_mem_gpr),
        .issue_mem_rd       (issue_mem_rd),
        .issue_mem_wr       (issue_mem_wr),
        .issue_gpr_op_depth (issue_gpr_op_depth),
        .issue_sgpr_wr_mask (issue_sgpr_wr_mask),
        .issue_dest_addr    (issue_dest_addr),
        .issue_exec_mask    (issue_exec_mask),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_ready      (mem_rsp_ready),
        .mem_rsp_data       (mem_rsp_data),
        .sgpr_wr_en         (sgpr_wr_en),
        .sgpr_wr_addr       (sgpr_wr_addr),
        .sgpr_wr_data       (sgpr_wr_data),
        .vgpr_wr_en         (vgpr_wr_en),
        .vgpr_wr_addr       (vgpr_wr_addr),
        .vgpr_wr_mask       (vgpr_wr_mask),
        .vgpr_wr_data       (vgpr_wr_data),
        .retire_valid       (retire_valid),
        .retire_wfid        (retire_wfid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic rand_data(output logic [VW-1:0] d);
        for (int i = 0; i < NW; i++) d[i*32 +: 32] = $urandom;
    endtask

    // No strobes, no retire, write addresses unchanged.
    task automatic check_quiet(input string tag);
        check({tag, "_sen"}, 64'(sgpr_wr_en), 64'd0);
        check({tag, "_ven"}, 64'(vgpr_wr_en), 64'd0);
        check({tag, "_ret"}, 64'(retire_valid), 64'd0);
        check({tag, "_shold"}, 64'(sgpr_wr_addr), 64'(last_saddr));
        check({tag, "_vhold"}, 64'(vgpr_wr_addr), 64'(last_vaddr));
    endtask

    task automatic drive_issue(input logic gpr, input logic rd, input logic wr, input logic [1:0] depth,
                               input logic [3:0] smask, input logic [9:0] base, input logic [5:0] wfid,
                               input logic [63:0] exec);
        issue_valid        = 1'b1;
        issue_mem_gpr      = gpr;
        issue_mem_rd       = rd;
        issue_mem_wr       = wr;
        issue_gpr_op_depth = depth;
        issue_sgpr_wr_mask = smask;
        issue_dest_addr    = base;
        issue_wfid         = wfid;
        issue_exec_mask    = exec;
    endtask

    task automatic drive_noise_issue();
        drive_issue(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                    10'($urandom), 6'($urandom), {$urandom, $urandom});
        issue_valid = 1'($urandom);
    endtask

    // Runs one op end to end; called and returns at a falling edge.
    task automatic run_op(input logic gpr, input logic rd, input logic wr, input logic [1:0] depth,
                          input logic [3:0] smask, input logic [9:0] base, input logic [5:0] wfid,
                          input logic [63:0] exec, input int gap_max);
        logic [VW-1:0] d;
        int nb;
        int g;
        int ea;
        bit last;
        check("idle_irdy", 64'(issue_ready), 64'd1);
        check("idle_mrdy", 64'(mem_rsp_ready), 64'd0);
        drive_issue(gpr, rd, wr, depth, smask, base, wfid, exec);
        rand_data(d);
        mem_rsp_data  = d;
        mem_rsp_valid = 1'($urandom);
        @(negedge clk);
        issue_valid   = 1'b0;
        mem_rsp_valid = 1'b0;
        if (!rd && !wr) begin
            check("nomem_ret", 64'(retire_valid), 64'd1);
            check("nomem_wfid", 64'(retire_wfid), 64'(wfid));
            check("nomem_mrdy", 64'(mem_rsp_ready), 64'd0);
            check("nomem_irdy", 64'(issue_ready), 64'd0);
            check("nomem_sen", 64'(sgpr_wr_en), 64'd0);
            check("nomem_ven", 64'(vgpr_wr_en), 64'd0);
        end else begin
            check("wait_mrdy", 64'(mem_rsp_ready), 64'd1);
            check("wait_irdy", 64'(issue_ready), 64'd0);
            check_quiet("issued");
            nb = rd ? int'(depth) + 1 : 1;
            for (int k = 0; k < nb; k++) begin
                g = $urandom_range(gap_max, 0);
                for (int j = 0; j < g; j++) begin
                    drive_noise_issue();
                    @(negedge clk);
                    check_quiet("gap");
                    check("gap_mrdy", 64'(mem_rsp_ready), 64'd1);
                end
                issue_valid   = 1'b0;
                rand_data(d);
                mem_rsp_data  = d;
                mem_rsp_valid = 1'b1;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                last = (k == nb - 1);
                if (rd && !gpr) begin
                    ea = (int'(base) + 4 * k) % 512;
                    check("sgpr_en", 64'(sgpr_wr_en), 64'(smask));
                    check("sgpr_addr", 64'(sgpr_wr_addr), 64'(ea));
                    check("sgpr_dlo", sgpr_wr_data[63:0], d[63:0]);
                    check("sgpr_dhi", sgpr_wr_data[127:64], d[127:64]);
                    check("sgpr_ven", 64'(vgpr_wr_en), 64'd0);
                    last_saddr = 9'(ea);
                end else if (rd) begin
                    ea = (int'(base) + k) % 1024;
                    check("vgpr_en", 64'(vgpr_wr_en), 64'd1);
                    check("vgpr_addr", 64'(vgpr_wr_addr), 64'(ea));
                    check("vgpr_mask", vgpr_wr_mask, exec);
                    check("vgpr_data", 64'(vgpr_wr_data == d), 64'd1);
                    check("vgpr_sen", 64'(sgpr_wr_en), 64'd0);
                    last_vaddr = 10'(ea);
                end else begin
                    check("st_sen", 64'(sgpr_wr_en), 64'd0);
                    check("st_ven", 64'(vgpr_wr_en), 64'd0);
                end
                check("beat_ret", 64'(retire_valid), 64'(last));
                check("beat_mrdy", 64'(mem_rsp_ready), 64'(!last));
                if (last) check("beat_wfid", 64'(retire_wfid), 64'(wfid));
            end
        end
        // DONE cycle: a new issue offered here must be ignored.
        drive_noise_issue();
        mem_rsp_valid = 1'($urandom);
        @(negedge clk);
        issue_valid   = 1'b0;
        mem_rsp_valid = 1'b0;
        check_quiet("post");
        check("post_irdy", 64'(issue_ready), 64'd1);
        check("post_mrdy", 64'(mem_rsp_ready), 64'd0);
    endtask

    initial begin
        logic [VW-1:0] d;
        rst                = 1'b1;
        issue_valid        = 1'b0;
        mem_rsp_valid      = 1'b0;
        mem_rsp_data       = '0;
        last_saddr         = '0;
        last_vaddr         = '0;
        drive_issue(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 10'd0, 6'd0, 64'd0);
        issue_valid        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_irdy", 64'(issue_ready), 64'd1);
        check("rst_mrdy", 64'(mem_rsp_ready), 64'd0);
        check("rst_sdata", sgpr_wr_data[63:0], 64'd0);
        check("rst_vmask", vgpr_wr_mask, 64'd0);
        check_quiet("rst");
        rst = 1'b0;
        @(negedge clk);

        // SGPR load, two beats at 0x10 then 0x14.
        run_op(1'b0, 1'b1, 1'b0, 2'd1, 4'b0011, 10'h010, 6'd9, 64'd0, 0);
        // VGPR load wrapping through the top of the register file.
        run_op(1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 10'h3FE, 6'd17, 64'hF0F0_F0F0_F0F0_F0F0, 3);
        // Store, depth ignored: one ack beat.
        run_op(1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 10'h020, 6'd33, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        // No memory traffic: retire on the next cycle.
        run_op(1'b0, 1'b0, 1'b0, 2'd2, 4'b1010, 10'h005, 6'd5, 64'd0, 0);
        // rd and wr both set behaves as a load; SGPR address wraps at 512.
        run_op(1'b0, 1'b1, 1'b1, 2'd2, 4'b1001, 10'h1FC, 6'd63, 64'd0, 1);

        // Reset between beats of a depth-3 VGPR load.
        drive_issue(1'b1, 1'b1, 1'b0, 2'd3, 4'd0, 10'h100, 6'd12, {$urandom, $urandom});
        @(negedge clk);
        issue_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_data(d);
            mem_rsp_data  = d;
            mem_rsp_valid = 1'b1;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            check("pre_rst_ven", 64'(vgpr_wr_en), 64'd1);
            check("pre_rst_vaddr", 64'(vgpr_wr_addr), 64'(10'h100 + 10'(k)));
        end
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        last_saddr = '0;
        last_vaddr = '0;
        check_quiet("mid_rst");
        check("mid_rst_irdy", 64'(issue_ready), 64'd1);
        check("mid_rst_mrdy", 64'(mem_rsp_ready), 64'd0);
        check("mid_rst_vmask", vgpr_wr_mask, 64'd0);
        mem_rsp_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_quiet("after_rst");
            check("after_rst_mrdy", 64'(mem_rsp_ready), 64'd0);
        end
        mem_rsp_valid = 1'b0;

        // Randomized ops.
        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                   10'($urandom), 6'($urandom), {$urandom, $urandom}, 3);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_gpr_writeback.md
LSU_GPR_WRITEBACK -- requirements
Module: lsu_gpr_writeback

Interface
REQ-001 Parameter LANES, default 64: wavefront lanes, also the VGPR write-mask width.
REQ-002 Parameter DW, default 32: dword width; VGPR write data is LANES*DW bits.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 issue_valid  in  1  decoded LSU op offered for writeback tracking.
REQ-006 issue_ready  out  1  block can accept an op (high only in IDLE).
REQ-007 issue_wfid  in  6  wavefront id of the op.
REQ-008 issue_mem_gpr  in  1  destination file: 0 = SGPR, 1 = VGPR.
REQ-009 issue_mem_rd  in  1  op is a load.
REQ-010 issue_mem_wr  in  1  op is a store.
REQ-011 issue_gpr_op_depth  in  2  beats minus one (0..3).
REQ-012 issue_sgpr_wr_mask  in  4  per-dword SGPR write enables per beat.
REQ-013 issue_dest_addr  in  10  base destination register; SGPR uses [8:0].
REQ-014 issue_exec_mask  in  LANES  active lanes for VGPR writes.
REQ-015 mem_rsp_valid  in  1  memory return beat (load data or store ack) present.
REQ-016 mem_rsp_ready  out  1  block accepts the beat (high only in WAIT).
REQ-017 mem_rsp_data  in  LANES*DW  return data; SGPR path uses [127:0].
REQ-018 sgpr_wr_en  out  4  per-dword SGPR write strobes.
REQ-019 sgpr_wr_addr  out  9  SGPR address of dword 0 of the beat.
REQ-020 sgpr_wr_data  out  128  four dwords, dword0 in [31:0].
REQ-021 vgpr_wr_en  out  1  VGPR write strobe.
REQ-022 vgpr_wr_addr  out  10  VGPR address.
REQ-023 vgpr_wr_mask  out  LANES  per-lane write enable.
REQ-024 vgpr_wr_data  out  LANES*DW  per-lane data, lane0 in [DW-1:0].
REQ-025 retire_valid / retire_wfid  out  1 / 6  one-cycle op-complete pulse and its wavefront.

Function
REQ-026 States IDLE, WAIT, DONE; issue accepted when issue_valid and issue_ready in the same cycle; all issue fields latched then; beat_cnt cleared.
REQ-027 IDLE->WAIT on accept when mem_rd or mem_wr is set; IDLE->DONE when neither set (no memory traffic, retire only); rd and wr both set treated as load.
REQ-028 WAIT load: each accepted beat (mem_rsp_valid && mem_rsp_ready) drives exactly one GPR write in the next cycle; beat_cnt increments; on beat_cnt == depth go DONE.
REQ-029 WAIT store: first accepted beat is the ack, no GPR write, go DONE regardless of depth.
REQ-030 SGPR write: sgpr_wr_en = latched mask, addr = base + 4*beat_cnt modulo 512, data = mem_rsp_data[127:0].
REQ-031 VGPR write: vgpr_wr_en = 1, addr = base + beat_cnt modulo 1024, mask = latched exec mask, data = mem_rsp_data.
REQ-032 Write strobes are single-cycle pulses; zero in every other cycle; data/address outputs hold last value when strobes are low.
REQ-033 DONE lasts one cycle: retire_valid = 1, retire_wfid = latched wfid, then IDLE; the last load write and retire coincide (one cycle after the last beat is accepted).
REQ-034 mem_rsp_valid outside WAIT ignored; issue_valid outside IDLE ignored; no back-to-back accept in the DONE cycle.

Reset
REQ-035 On rst: state IDLE, beat_cnt 0, all strobes and retire_valid 0, addresses and data 0; an op in flight is discarded with no write and no retire.

Structure
REQ-036 Shared package lsu_wb_pkg holds the state enum, LANES, DW, SGPR_ADDR_W = 9 and VGPR_ADDR_W = 10.
REQ-037 One sub-module is natural: lsu_wb_addr_gen (beat counter plus SGPR/VGPR address arithmetic); everything else stays inline.

Verification
REQ-038 SGPR load, depth 1, mask 0011, base 0x10, two beats -> sgpr_wr_en 0011 at addr 0x10, then 0x14; retire with the last write.
REQ-039 VGPR load, depth 3, base 0x3FE, exec 0xF0F0..., four beats with valid gaps -> addrs 0x3FE, 0x3FF, 0x000, 0x001, mask unchanged; one retire.
REQ-040 Store, depth 3 -> one ack beat, no write strobes, retire_valid 1 cycle later, ready=0 afterwards until IDLE.
REQ-041 issue with rd=wr=0, wfid 5 -> retire_wfid 5 on the next cycle; mem_rsp_ready never high.
REQ-042 rst asserted between beat 1 and beat 2 of a depth-3 VGPR load -> no further writes, no retire, issue_ready 1 after reset.
